// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters (M0 = CPU,
// M1 = loader/DMA). One transaction in flight at a time; round-robin or fixed
// M0 priority. Memory read data returns RD_LAT cycles after the read strobe.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   mX_req_i/we_i/addr_i/wdata_i  request from master X, held until mX_gnt_o
//   mX_gnt_o                  one-cycle pulse: request issued to memory
//   mX_rvalid_o, mX_rdata_o   one-cycle read-return pulse and read data
//   memread_o/memwrite_o      memory strobes (asserted only in ACCESS)
//   memaddr_o/memwdata_o      latched address / write data of the winner
//   memrdata_i                memory read data, valid RD_LAT cycles after read
//   busy_o                    high whenever a transaction is in progress
module mem_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RD_LAT  = 1,
  parameter int PRIO_M0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          memread_o,
  output logic          memwrite_o,
  output logic [AW-1:0] memaddr_o,
  output logic [DW-1:0] memwdata_o,
  input  logic [DW-1:0] memrdata_i,
  output logic          busy_o
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;     // 0 = M0, 1 = M1
  logic          last_q, last_d;   // master granted most recently
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;              // M0 wins the first tie
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // a lone requester always wins; a tie goes to M0 under fixed
          // priority, otherwise to whichever master was not granted last
          if (m0_req_i && m1_req_i)
            win_d = (PRIO_M0 != 0) ? 1'b0 : ~last_q;
          else
            win_d = m1_req_i;
          last_d  = win_d;
          we_d    = win_d ? m1_we_i    : m0_we_i;
          addr_d  = win_d ? m1_addr_i  : m0_addr_i;
          wdata_d = win_d ? m1_wdata_i : m0_wdata_i;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = CW'(RD_LAT - 1);
        if (we_q)             state_d = S_IDLE;
        else if (RD_LAT == 1) state_d = S_RESP;
        else                  state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) state_d = S_RESP;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        if (win_q) rdata1_d = memrdata_i;
        else       rdata0_d = memrdata_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All control outputs decode directly from state registers.
  assign busy_o      = (state_q != S_IDLE);
  assign memread_o   = (state_q == S_ACCESS) && !we_q;
  assign memwrite_o  = (state_q == S_ACCESS) &&  we_q;
  assign memaddr_o   = addr_q;
  assign memwdata_o  = wdata_q;
  assign m0_gnt_o    = (state_q == S_ACCESS) && !win_q;
  assign m1_gnt_o    = (state_q == S_ACCESS) &&  win_q;
  assign m0_rvalid_o = (state_q == S_RESP)   && !win_q;
  assign m1_rvalid_o = (state_q == S_RESP)   &&  win_q;

  // Memory data is only valid during RESP, so it is forwarded that cycle and
  // held in the per-master register afterwards.
  assign m0_rdata_o  = m0_rvalid_o ? memrdata_i : rdata0_q;
  assign m1_rdata_o  = m1_rvalid_o ? memrdata_i : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // DUT A: round-robin, RD_LAT=2
  logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
  logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_memread, a_memwrite, a_busy;
  logic [31:0] a_memaddr, a_memwdata;
  logic [31:0] a_memrdata = 0;

  // DUT B: fixed M0 priority, RD_LAT=1
  logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_memread, b_memwrite, b_busy;
  logic [31:0] b_memaddr, b_memwdata;
  logic [31:0] b_memrdata = 32'hCAFEF00D;

  mem_arbiter #(.DW(32), .AW(32), .RD_LAT(RD_LAT), .PRIO_M0(0)) u_a (
    .clk(clk), .rst(rst),
    .m0_req_i(a_m0_req), .m0_we_i(a_m0_we), .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
    .m1_req_i(a_m1_req), .m1_we_i(a_m1_we), .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
    .memread_o(a_memread), .memwrite_o(a_memwrite), .memaddr_o(a_memaddr),
    .memwdata_o(a_memwdata), .memrdata_i(a_memrdata), .busy_o(a_busy));

  mem_arbiter #(.DW(32), .AW(32), .RD_LAT(1), .PRIO_M0(1)) u_b (
    .clk(clk), .rst(rst),
    .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .memread_o(b_memread), .memwrite_o(b_memwrite), .memaddr_o(b_memaddr),
    .memwdata_o(b_memwdata), .memrdata_i(b_memrdata), .busy_o(b_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory behind DUT A ----------------
  logic [31:0] mem [logic [31:0]];
  logic [32:0] rpipe [0:RD_LAT];
  int cyc = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin
    for (int i = 0; i <= RD_LAT; i++) rpipe[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = RD_LAT; i > 0; i--) rpipe[i] = rpipe[i-1];
      rpipe[0] = {a_memread, memval(a_memaddr)};
      if (a_memwrite) mem[a_memaddr] = a_memwdata;
      a_memrdata = rpipe[RD_LAT][32] ? rpipe[RD_LAT][31:0] : (32'hA5A50000 ^ 32'(cyc));
    end
  end

  // ---------------- transaction-timeline model of DUT A ----------------
  // A grant decided at the end of idle cycle T occupies the memory until
  // free_at; gnt lands at T+1 and read data at T+1+RD_LAT.
  int          free_at, g_cyc, rv_cyc;
  bit          g_who, g_we, last;
  logic [31:0] g_addr, g_wdata, g_rd;
  logic [31:0] hold [2];

  task automatic model_reset();
    free_at = 0; g_cyc = -1; rv_cyc = -1; last = 1'b1;
    g_who = 0; g_we = 0; g_addr = 0; g_wdata = 0; g_rd = 0;
    hold[0] = 0; hold[1] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        if (cyc == rv_cyc) hold[g_who] = g_rd;
        if (cyc >= free_at && (a_m0_req || a_m1_req)) begin
          if (a_m0_req && a_m1_req) g_who = ~last;
          else                      g_who = a_m1_req;
          last    = g_who;
          g_we    = g_who ? a_m1_we    : a_m0_we;
          g_addr  = g_who ? a_m1_addr  : a_m0_addr;
          g_wdata = g_who ? a_m1_wdata : a_m0_wdata;
          g_cyc   = cyc + 1;
          if (g_we) begin
            rv_cyc  = -1;
            free_at = cyc + 2;
          end else begin
            g_rd    = memval(g_addr);
            rv_cyc  = cyc + 1 + RD_LAT;
            free_at = cyc + 2 + RD_LAT;
          end
        end
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare for DUT A ----------------
  initial begin
    logic [6:0] exp_ctl;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_ctl = {cyc == g_cyc && !g_who, cyc == g_cyc && g_who,
                   cyc == g_cyc && !g_we,  cyc == g_cyc && g_we,
                   cyc < free_at,
                   cyc == rv_cyc && !g_who, cyc == rv_cyc && g_who};
        chk("ctl{g0,g1,rd,wr,busy,rv0,rv1}",
            {a_m0_gnt, a_m1_gnt, a_memread, a_memwrite, a_busy, a_m0_rvalid, a_m1_rvalid}, exp_ctl);
        chk("m0_rdata", a_m0_rdata, (cyc == rv_cyc && !g_who) ? g_rd : hold[0]);
        chk("m1_rdata", a_m1_rdata, (cyc == rv_cyc &&  g_who) ? g_rd : hold[1]);
        if (cyc == g_cyc) begin
          chk("memaddr", a_memaddr, g_addr);
          if (g_we) chk("memwdata", a_memwdata, g_wdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers (DUT A) ----------------
  task automatic req_a(input bit who, input bit we, input logic [31:0] ad, input logic [31:0] wd);
    if (!who) begin a_m0_req = 1; a_m0_we = we; a_m0_addr = ad; a_m0_wdata = wd; end
    else      begin a_m1_req = 1; a_m1_we = we; a_m1_addr = ad; a_m1_wdata = wd; end
  endtask

  task automatic drop_a(input bit who);
    if (!who) a_m0_req = 0;
    else      a_m1_req = 0;
  endtask

  task automatic wait_gnt_a(input bit who);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((!who && a_m0_gnt) || (who && a_m1_gnt)) seen = 1;
    end
    chk("gnt_seen", seen, 1);
  endtask

  task automatic wait_idle_a();
    bit idle = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!a_busy) idle = 1;
    end
    chk("idle_seen", idle, 1);
  endtask

  task automatic issue_a(input bit who, input bit we, input logic [31:0] ad, input logic [31:0] wd);
    req_a(who, we, ad, wd);
    wait_gnt_a(who);
    drop_a(who);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    bit [5:0] order;
    int       n, m0c, m1c, waitn;
    bit       seen;

    #1 rst = 1'b0;
    chk_en = 1'b1;

    // 1: reset with both requests high, then M0 wins the first tie
    req_a(0, 0, 32'h10, 0);
    req_a(1, 0, 32'h20, 0);
    repeat (2) @(negedge clk);
    chk("rst_outputs", {a_m0_gnt, a_m1_gnt, a_memread, a_memwrite, a_busy, a_m0_rvalid, a_m1_rvalid}, 0);
    chk("rst_rdata", {a_m0_rdata, a_m1_rdata}, 0);
    chk("rst_b_busy", {b_busy, b_m0_gnt, b_m1_gnt}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_gnt_m0", {a_m0_gnt, a_m1_gnt}, 2'b10);
    drop_a(0);
    wait_gnt_a(1);
    drop_a(1);
    wait_idle_a();

    // 2: M0 read of 0x40 with RD_LAT=2
    mem[32'h40] = 32'hDEADBEEF;
    req_a(0, 0, 32'h40, 0);                  // cycle T
    @(negedge clk);                          // T+1
    chk("t2_gnt_rd", {a_m0_gnt, a_memread, a_memwrite}, 3'b110);
    chk("t2_addr", a_memaddr, 32'h40);
    drop_a(0);
    @(negedge clk);                          // T+2
    chk("t2_wait", {a_busy, a_m0_rvalid}, 2'b10);
    @(negedge clk);                          // T+3
    chk("t2_rvalid", a_m0_rvalid, 1);
    chk("t2_rdata", a_m0_rdata, 32'hDEADBEEF);
    @(negedge clk);                          // T+4
    chk("t2_idle", {a_busy, a_m0_rvalid}, 2'b00);
    chk("t2_rdata_held", a_m0_rdata, 32'hDEADBEEF);

    // 3: M1 write 0x100 <= 0x12345678, then read back by M1
    req_a(1, 1, 32'h100, 32'h12345678);     // cycle T
    @(negedge clk);                          // T+1
    chk("t3_strobe", {a_m1_gnt, a_m0_gnt, a_memwrite, a_memread}, 4'b1010);
    chk("t3_addr", a_memaddr, 32'h100);
    chk("t3_wdata", a_memwdata, 32'h12345678);
    drop_a(1);
    @(negedge clk);                          // T+2
    chk("t3_idle", {a_busy, a_m1_rvalid, a_m0_rvalid}, 3'b000);
    issue_a(1, 0, 32'h100, 0);
    repeat (RD_LAT) @(negedge clk);
    chk("t3_readback", {a_m1_rvalid, a_m1_rdata}, {1'b1, 32'h12345678});
    wait_idle_a();

    // 4: round-robin with both masters holding read requests
    mem[32'h200] = 32'h11112222;
    mem[32'h300] = 32'h33334444;
    req_a(0, 0, 32'h200, 0);
    req_a(1, 0, 32'h300, 0);
    n = 0;
    order = '0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (a_m0_gnt)      begin order[n] = 1'b0; n++; end
      else if (a_m1_gnt) begin order[n] = 1'b1; n++; end
    end
    drop_a(0);
    drop_a(1);
    chk("t4_count", n, 6);
    chk("t4_order", order, 6'b101010);
    wait_idle_a();

    // 5: fixed priority (DUT B); M0 back-to-back writes starve M1
    b_m0_req = 1; b_m0_we = 1; b_m0_addr = 32'h8; b_m0_wdata = 32'h1;
    b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'hC; b_m1_wdata = 32'h2;
    m0c = 0; m1c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m0c += int'(b_m0_gnt);
      m1c += int'(b_m1_gnt);
    end
    chk("t5_m1_starved", m1c, 0);
    chk("t5_m0_grants", m0c, 10);
    b_m0_req = 0;
    seen = 0; waitn = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      waitn++;
      if (b_m0_gnt) m0c++;
      if (b_m1_gnt) seen = 1;
    end
    b_m1_req = 0;
    chk("t5_m1_granted", {seen, waitn[7:0]}, {1'b1, 8'd1});
    chk("t5_no_m0_after_drop", m0c, 10);
    @(negedge clk);                          // DUT B idle again
    b_m1_we = 0; b_m1_addr = 32'h10; b_m1_req = 1;
    @(negedge clk);
    chk("t5_rd_gnt", {b_m1_gnt, b_memread, b_memaddr}, {2'b11, 32'h10});
    b_m1_req = 0;
    @(negedge clk);
    chk("t5_rd_rvalid", {b_m1_rvalid, b_m1_rdata}, {1'b1, 32'hCAFEF00D});
    @(negedge clk);
    chk("t5_rd_idle", {b_busy, b_m1_rvalid}, 2'b00);

    // 6: reset during WAIT aborts the read
    wait_idle_a();
    req_a(0, 0, 32'h40, 0);
    @(negedge clk);
    chk("t6_gnt", a_m0_gnt, 1);
    drop_a(0);
    @(negedge clk);
    chk("t6_in_wait", {a_busy, a_m0_rvalid}, 2'b10);
    #2 rst = 1'b0;
    #1;
    chk("t6_abort", {a_busy, a_m0_rvalid, a_memread, a_m0_gnt}, 4'b0000);
    chk("t6_rdata_cleared", a_m0_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rvalid", a_m0_rvalid, 0);
    end
    rst = 1'b1;
    issue_a(1, 1, 32'h500, 32'h0BADF00D);
    wait_idle_a();
    issue_a(0, 0, 32'h500, 0);
    repeat (RD_LAT) @(negedge clk);
    chk("t6_after_reset_read", {a_m0_rvalid, a_m0_rdata}, {1'b1, 32'h0BADF00D});
    wait_idle_a();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
